// File: rtl/chan_mux_pkg.sv
// Shared constants and FSM encoding for the channel multiplexer/arbiter.
// Imported by chan_mux_arb and rr_pick.
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/chan_mux_arb_rr_pick.sv
// Rotating-priority request picker: first requester after ptr wins,
// wrapping from N-1 back to 0 (ptr itself is checked last).
module rr_pick
  import chan_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  always_comb begin
    logic [SELW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = SELW'((int'(ptr) + k) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/chan_mux_arb.sv
// N-channel registered multiplexer with manual and round-robin grant modes,
// valid/ready on every channel and a one-entry output register.
// Optional even-parity output enabled by defining CHAN_MUX_PARITY_EN.
module chan_mux_arb
  import chan_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
`ifdef CHAN_MUX_PARITY_EN
  ,
  output logic            out_parity
`endif
);

  function automatic logic parity_even(input logic [W-1:0] d);
    return ^d;
  endfunction

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q;
  logic [W-1:0]    data_p1;
  logic [SELW-1:0] chan_p1;

  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic            man_vld;
  logic [SELW-1:0] man_idx;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic [W-1:0]    gnt_data_p0;
  logic            can_load;
  logic            load;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Stage p0: grant decision and input selection
  always_comb begin
    man_vld = 1'b0;
    man_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i) && in_valid[i]) begin
        man_vld = 1'b1;
        man_idx = SELW'(i);
      end
    end
  end

  assign gnt_vld  = (mode == MODE_RR) ? rr_vld : man_vld;
  assign gnt_idx  = (mode == MODE_RR) ? rr_idx : man_idx;
  assign out_valid = (state_q == ST_FULL);
  assign can_load = !out_valid || out_ready;
  // rst_n gates the handshake so no channel sees in_ready while held in reset
  assign load     = rst_n && can_load && gnt_vld;

  always_comb begin
    in_ready    = '0;
    gnt_data_p0 = '0;
    if (load) in_ready[gnt_idx] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) gnt_data_p0 = in_data[i*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL: begin
        if (load)           state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      chan_p1 <= '0;
      ptr_q   <= SELW'(N - 1);
    end else if (load) begin
      data_p1 <= gnt_data_p0;
      chan_p1 <= gnt_idx;
      ptr_q   <= gnt_idx;
    end
  end

  assign out_data = data_p1;
  assign out_chan = chan_p1;

`ifdef CHAN_MUX_PARITY_EN
  logic parity_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    parity_p1 <= 1'b0;
    else if (load) parity_p1 <= parity_even(gnt_data_p0);
  end

  assign out_parity = parity_p1;
`endif

endmodule

// File: tb/tb_chan_mux_arb.sv
// Directed bench for chan_mux_arb (N=4, W=8) with a transaction-level
// reference model and per-cycle output comparison.
module tb_chan_mux_arb;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  chd [4];
  logic [31:0] in_data;
  logic [3:0]  iv;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        ordy;
`ifdef CHAN_MUX_PARITY_EN
  logic        out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  assign in_data = {chd[3], chd[2], chd[1], chd[0]};

  chan_mux_arb #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (iv),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (ordy)
`ifdef CHAN_MUX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one held word plus the last granted channel
  logic       mv   = 1'b0;
  logic [7:0] md   = 8'h00;
  int         mc   = 0;
  int         mptr = 3;
  int         mg;

  function automatic int exp_grant(input logic m, input logic [1:0] s,
                                   input logic [3:0] v, input int p);
    int c;
    if (m == 1'b0) return v[s] ? int'(s) : -1;
    for (int k = 1; k <= 4; k++) begin
      c = (p + k) % 4;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv = 1'b0; md = 8'h00; mc = 0; mptr = 3;
    end else begin
      mg = exp_grant(mode, sel, iv, mptr);
      if ((!mv || ordy) && mg >= 0) begin
        mv = 1'b1; md = chd[mg[1:0]]; mc = mg; mptr = mg;
      end else if (ordy) begin
        mv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] exp_ir;
    if (rst_n) begin
      g = exp_grant(mode, sel, iv, mptr);
      exp_ir = 4'b0000;
      if ((!mv || ordy) && g >= 0) exp_ir[g[1:0]] = 1'b1;
      check("cyc_in_ready", 32'(in_ready), 32'(exp_ir));
      check("cyc_out_valid", 32'(out_valid), 32'(mv));
      if (mv) begin
        check("cyc_out_data", 32'(out_data), 32'(md));
        check("cyc_out_chan", 32'(out_chan), 32'(mc));
`ifdef CHAN_MUX_PARITY_EN
        check("cyc_out_parity", 32'(out_parity), 32'(^md));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] fair [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] wrap [3] = '{2'd0, 2'd1, 2'd0};
  // {mode, sel, in_valid, out_ready}
  logic [7:0] tbl [12] = '{8'b0_01_0010_1, 8'b0_11_1000_0, 8'b1_00_1010_0, 8'b1_00_1010_1,
                           8'b1_00_1010_1, 8'b0_00_0110_1, 8'b1_00_0110_1, 8'b1_00_0000_1,
                           8'b1_00_1001_1, 8'b0_10_1011_1, 8'b1_00_1111_0, 8'b1_00_0001_1};

  initial begin
    mode = 1'b0; sel = 2'd0; iv = 4'b0000; ordy = 1'b0;
    for (int i = 0; i < 4; i++) chd[i] = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    iv = 4'b1111; mode = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_chan", 32'(out_chan), 32'h0);
`ifdef CHAN_MUX_PARITY_EN
    check("rst_out_parity", 32'(out_parity), 32'h0);
`endif

    // manual select of channel 2
    rst_n = 1'b1; mode = 1'b0; sel = 2'd2; iv = 4'b0100; chd[2] = 8'hA5; ordy = 1'b1;
    #1;
    check("man_in_ready", 32'(in_ready), 32'h4);
    step();
    check("man_out_data", 32'(out_data), 32'hA5);
    check("man_out_chan", 32'(out_chan), 32'h2);
    check("man_out_valid", 32'(out_valid), 32'h1);
    iv = 4'b0000;
    step();
    check("drain_valid", 32'(out_valid), 32'h0);

    // round-robin fairness straight out of reset
    rst_n = 1'b0; #2; rst_n = 1'b1;
    mode = 1'b1; iv = 4'b1111; ordy = 1'b1;
    for (int i = 0; i < 4; i++) chd[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_fair_chan", 32'(out_chan), 32'(fair[k]));
      check("rr_fair_valid", 32'(out_valid), 32'h1);
    end

    // skip and wrap after a grant to channel 2
    iv = 4'b0100;
    step();
    check("rr_ptr2_chan", 32'(out_chan), 32'h2);
    iv = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr_wrap_chan", 32'(out_chan), 32'(wrap[k]));
    end

    // backpressure with a mode change while full
    mode = 1'b0; sel = 2'd0; iv = 4'b0001; chd[0] = 8'h3C;
    step();
    check("bp_load", 32'(out_data), 32'h3C);
    ordy = 1'b0; mode = 1'b1; iv = 4'b0010; chd[1] = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      check("bp_hold", 32'(out_data), 32'h3C);
    end
    ordy = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h2);
    step();
    check("bp_release_data", 32'(out_data), 32'h5A);
    check("bp_release_chan", 32'(out_chan), 32'h1);
    iv = 4'b0000;
    step();
    check("idle_valid", 32'(out_valid), 32'h0);

    // mixed directed patterns, checked by the per-cycle compare
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < 4; c++) chd[c] = 8'(k * 37 + c * 11);
      {mode, sel, iv, ordy} = tbl[k];
      step();
    end

    // asynchronous reset while a word is held
    mode = 1'b1; iv = 4'b1111; ordy = 1'b0;
    step();
    check("mid_full", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_chan", 32'(out_chan), 32'h0);
    check("post_rst_valid", 32'(out_valid), 32'h1);

`ifdef CHAN_MUX_PARITY_EN
    mode = 1'b0; sel = 2'd1; iv = 4'b0010; ordy = 1'b1; chd[1] = 8'h07;
    step();
    check("parity_07", 32'(out_parity), 32'h1);
    chd[1] = 8'h03;
    step();
    check("parity_03", 32'(out_parity), 32'h0);
`endif

    iv = 4'b0000; ordy = 1'b1;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
